// File: rtl/msrv32_muldiv.sv
// msrv32_muldiv -- iterative RV32M multiply/divide unit (radix-2, one bit per cycle).
//
// Sits next to the single-cycle ALU in execute. The decoder starts it on
// M-extension instructions; the pipeline stalls on busy_out until the
// registered valid_out strobe delivers result_out.
//
// Ports
//   ms_riscv32_mp_clk_in  clock, rising edge
//   ms_riscv32_mp_rst_in  synchronous active-high reset
//   start_in              request, sampled only while idle
//   funct3_in             RV32M funct3 (MUL..REMU)
//   op_1_in / op_2_in     rs1 / rs2
//   flush_in              abort an in-flight operation
//   busy_out              FSM not idle
//   valid_out             one-cycle result strobe
//   result_out            result, held until the next strobe
//
// Optional feature: define MSRV32_MULDIV_EARLY_OUT_EN to finish divide-by-zero,
// signed-overflow and multiply-by-zero in one cycle. Results are identical
// either way.
module msrv32_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             start_in,
    input  logic [2:0]       funct3_in,
    input  logic [WIDTH-1:0] op_1_in,
    input  logic [WIDTH-1:0] op_2_in,
    input  logic             flush_in,
    output logic             busy_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] result_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         f_q;
    logic [WIDTH-1:0]   m_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0] acc_q;    // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic               neg_q;    // final result must be negated
    logic [WIDTH-1:0]   res_q;
    logic               vld_q;

    // ---------------- operand preparation at start ----------------
    logic             is_div, sgn_op1, sgn_op2, s1, s2, neg_start;
    logic [WIDTH-1:0] mag1, mag2;
    logic             accept;

    always_comb begin
        is_div    = funct3_in[2];
        sgn_op1   = (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                    (funct3_in == 3'b100) || (funct3_in == 3'b110);
        sgn_op2   = (funct3_in == 3'b001) || (funct3_in == 3'b100) ||
                    (funct3_in == 3'b110);
        s1        = sgn_op1 & op_1_in[WIDTH-1];
        s2        = sgn_op2 & op_2_in[WIDTH-1];
        mag1      = s1 ? -op_1_in : op_1_in;
        mag2      = s2 ? -op_2_in : op_2_in;
        // Remainder follows the dividend. Quotient by zero must stay all-ones,
        // so its negation is suppressed there; the overflow case falls out of
        // the unsigned datapath with no fix needed.
        if (is_div)
            neg_start = funct3_in[1] ? s1 : ((s1 ^ s2) & (op_2_in != '0));
        else
            neg_start = s1 ^ s2;
        accept    = (state_q == IDLE) && start_in && !flush_in;
    end

    // ---------------- early-out detection ----------------
    logic             early_hit;
    logic [WIDTH-1:0] early_res;

`ifdef MSRV32_MULDIV_EARLY_OUT_EN
    logic div_zero, div_ovf, mul_zero;
    always_comb begin
        div_zero  = is_div && (op_2_in == '0);
        div_ovf   = is_div && !funct3_in[0] && (op_1_in == MIN_NEG) && (op_2_in == '1);
        mul_zero  = !is_div && ((op_1_in == '0) || (op_2_in == '0));
        early_hit = div_zero || div_ovf || mul_zero;
        if (mul_zero)
            early_res = '0;
        else if (div_zero)
            early_res = funct3_in[1] ? op_1_in : '1;
        else
            early_res = funct3_in[1] ? '0 : op_1_in;
    end
`else
    always_comb begin
        early_hit = 1'b0;
        early_res = '0;
    end
`endif

    // ---------------- one iteration ----------------
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] acc_n, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, res_calc;
    logic               last;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, m_q};
        if (f_q[2]) begin
            if (!diff[WIDTH])
                acc_n = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_n = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_n = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod_fix = neg_q ? -acc_n : acc_n;
        q_fix    = neg_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
        r_fix    = neg_q ? -acc_n[2*WIDTH-1:WIDTH] : acc_n[2*WIDTH-1:WIDTH];
        if (f_q[2])
            res_calc = f_q[1] ? r_fix : q_fix;
        else if (f_q[1:0] == 2'b00)
            res_calc = prod_fix[WIDTH-1:0];
        else
            res_calc = prod_fix[2*WIDTH-1:WIDTH];
        last = (cnt_q == CW'(WIDTH - 1));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) state_q <= IDLE;
        else                      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = early_hit ? DONE : CALC;
            CALC: begin
                if (flush_in)  state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            cnt_q <= '0;
            f_q   <= '0;
            m_q   <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    cnt_q <= '0;
                    f_q   <= funct3_in;
                    m_q   <= is_div ? mag2 : mag1;
                    acc_q <= {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
                    neg_q <= neg_start;
                    if (early_hit) begin
                        res_q <= early_res;
                        vld_q <= 1'b1;
                    end
                end
                CALC: if (!flush_in) begin
                    acc_q <= acc_n;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        res_q <= res_calc;
                        vld_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out   = (state_q != IDLE);
    assign valid_out  = vld_q;
    assign result_out = res_q;

endmodule

// File: tb/tb_msrv32_muldiv.sv
// Directed + randomised bench for msrv32_muldiv at WIDTH=32.
module tb_msrv32_muldiv;

    localparam int W = 32;
    localparam int FULL_LAT = W + 1;
`ifdef MSRV32_MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = W + 1;
`endif

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]   f = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, valid;
    logic [W-1:0] res;

    msrv32_muldiv #(.WIDTH(W)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .start_in(start),
        .funct3_in(f),
        .op_1_in(a),
        .op_2_in(b),
        .flush_in(flush),
        .busy_out(busy),
        .valid_out(valid),
        .result_out(res)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] last_res = '0;

    // strobe monitor
    int vcount = 0, consec = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (valid) vcount++;
        if (valid && prev_v) consec++;
        prev_v = valid;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, sp;
        logic [63:0] up, ux, uy;
        logic ovf;
        sx  = $signed(x);
        sy  = $signed(y);
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (fn)
            3'd0: begin up = ux * uy; return up[31:0]; end
            3'd1: begin sp = sx * sy; return sp[63:32]; end
            3'd2: begin sp = sx * longint'(uy); return sp[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin
                if (y == 0) return '1;
                if (ovf)    return x;
                sp = sx / sy; return sp[31:0];
            end
            3'd5: return (y == 0) ? '1 : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf)    return '0;
                sp = sx % sy; return sp[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
        if (fn[2] && y == 0) return SPEC_LAT;
        if (fn[2] && !fn[0] && x == 32'h8000_0000 && y == '1) return SPEC_LAT;
        if (!fn[2] && (x == 0 || y == 0)) return SPEC_LAT;
        return FULL_LAT;
    endfunction

    // Issue one op, wait for its strobe (bounded), compare against the queue.
    task automatic run_op(input logic [2:0] fi, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic [W-1:0] exp, input int exp_lat, input string tag);
        int lat;
        logic busy_ok;
        sb.push_back(exp);
        @(negedge clk); start = 1'b1; f = fi; a = ai; b = bi;
        @(posedge clk); lat = 1;
        @(negedge clk); start = 1'b0; f = ~fi; a = ~ai; b = ~bi;
        busy_ok = 1'b1;
        forever begin
            if (!busy) busy_ok = 1'b0;
            if (valid || lat >= 100) break;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, busy_ok, 1'b1);
        chk(tag, valid ? res : 'x, sb.pop_front());
        last_res = exp;
        @(posedge clk); @(negedge clk);
        chk({tag, "_after"}, {busy, valid}, 2'b00);
    endtask

    initial begin
        int v0;
        logic [2:0] rf;
        logic [W-1:0] ra, rb, re;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {busy, valid}, 2'b00);
        chk("reset_res", res, '0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, FULL_LAT, "mulh");
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, FULL_LAT, "mulhsu");
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, FULL_LAT, "mulhu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT, "rem");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, FULL_LAT, "divu");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, FULL_LAT, "remu");
        run_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, "divu_z");
        run_op(3'd7, 32'h1234, 32'd0, 32'h0000_1234, SPEC_LAT, "remu_z");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, "div_z_neg");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPEC_LAT, "rem_z_neg");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT, "rem_ovf");
        run_op(3'd1, 32'd0, 32'h8000_0000, 32'h0000_0000, SPEC_LAT, "mulh_zero");

        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 9) ? 32'd3 : $urandom;
            if (i == 4) ra = 32'hFFFF_FF00;
            re = model(rf, ra, rb);
            run_op(rf, ra, rb, re, lat_of(rf, ra, rb), $sformatf("rnd%0d_f%0d", i, rf));
        end

        // start together with flush while idle: request dropped
        @(negedge clk); start = 1'b1; flush = 1'b1; f = 3'd5; a = 32'd9; b = 32'd3;
        @(posedge clk);
        @(negedge clk); start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", busy, 1'b0);

        // flush at iteration 10
        v0 = vcount;
        @(negedge clk); start = 1'b1; f = 3'd3; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk);
        @(negedge clk); flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("flush_no_valid", vcount - v0, 0);
        chk("flush_res_hold", res, last_res);

        // start pulses during CALC and DONE are ignored
        v0 = vcount;
        @(negedge clk); start = 1'b1; f = 3'd5; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); start = 1'b1; f = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 100 && !valid; k++) begin
            @(posedge clk); @(negedge clk);
        end
        chk("ign_res", valid ? res : 'x, 32'd14);
        start = 1'b1; f = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        chk("ign_done_busy", busy, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("ign_one_valid", vcount - v0, 1);
        chk("ign_res_hold", res, 32'd14);

        // reset at iteration 5
        @(negedge clk); start = 1'b1; f = 3'd0; a = 32'd11; b = 32'd13;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("midrst_outs", {busy, valid}, 2'b00);
        chk("midrst_res", res, '0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("midrst_quiet", {busy, valid}, 2'b00);

        chk("no_consec_valid", consec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
